// File: rtl/rtc_pkg.sv
// rtc_pkg: shared limits and the compact time type for the rtc_clock_p slice.
package rtc_pkg;

  localparam int SEC_MAX     = 59;
  localparam int MIN_MAX     = 59;
  localparam int HOUR_MAX    = 23;
  localparam int HOUR12_NOON = 12;

  // Compact time triple; the fields hold validated 24-hour values only.
  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } rtc_time_t;

endpackage

// File: rtl/rtc_clock_p_mod_counter.sv
// mod_counter: wrap-around counter 0..MAX with load priority and carry-out.
module mod_counter
  import rtc_pkg::*;
#(
  parameter int MAX = 59,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] value_q, value_d;

  // Load overrides increment; increment wraps from MAX back to zero.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      value_d = (value_q == MAX_V) ? '0 : value_q + W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc && (value_q == MAX_V);

endmodule

// File: rtl/rtc_clock_p.sv
// rtc_clock_p: prescaled hh:mm:ss real-time clock with load, run/pause,
// 12/24-hour display and day rollover pulse.
// Optional alarm logic and ports are built when RTC_ALARM_EN is defined.
module rtc_clock_p
  import rtc_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int CNT_W    = 32,
  parameter int FIELD_W  = 8
) (
  input  logic               clk,
  input  logic               rset,
  input  logic               run,
  input  logic               mode12,
  input  logic               set_vld,
  input  logic [FIELD_W-1:0] set_hour,
  input  logic [FIELD_W-1:0] set_min,
  input  logic [FIELD_W-1:0] set_sec,
  output logic               set_err,
  output logic [FIELD_W-1:0] sec,
  output logic [FIELD_W-1:0] min,
  output logic [FIELD_W-1:0] hour,
  output logic               pm,
  output logic               sec_tick,
  output logic               day_tick
`ifdef RTC_ALARM_EN
  ,
  input  logic               alarm_set,
  input  logic [FIELD_W-1:0] alarm_hour,
  input  logic [FIELD_W-1:0] alarm_min,
  input  logic               alarm_clr,
  output logic               alarm
`endif
);

  localparam logic [CNT_W-1:0]   TERM     = CNT_W'(CLK_FREQ - 1);
  localparam logic [FIELD_W-1:0] SEC_LIM  = FIELD_W'(SEC_MAX);
  localparam logic [FIELD_W-1:0] MIN_LIM  = FIELD_W'(MIN_MAX);
  localparam logic [FIELD_W-1:0] HOUR_LIM = FIELD_W'(HOUR_MAX);
  localparam logic [FIELD_W-1:0] NOON_V   = FIELD_W'(HOUR12_NOON);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick, load_in_range, load_ok, tick_eff;
  logic               sec_carry, min_carry, hour_carry;
  logic [FIELD_W-1:0] sec_int, min_int, hour_int;
  logic               set_err_q, set_err_d;
  logic               sec_tick_q, sec_tick_d;
  logic               day_tick_q, day_tick_d;

  assign tick          = run && (cnt_q == TERM);
  assign load_in_range = (set_hour <= HOUR_LIM) && (set_min <= MIN_LIM) && (set_sec <= SEC_LIM);
  assign load_ok       = set_vld && load_in_range;
  assign tick_eff      = tick && !load_ok;

`ifdef RTC_ALARM_EN
  rtc_time_t alarm_q, alarm_d;
  rtc_time_t land_tick, land_load;
  logic      armed_q, armed_d;
  logic      alarm_flag_q, alarm_flag_d;
  logic      alarm_in_range, alarm_ok, alarm_hit;

  assign alarm_in_range = (alarm_hour <= HOUR_LIM) && (alarm_min <= MIN_LIM);
  assign alarm_ok       = alarm_set && alarm_in_range;
`endif

  // Prescaler: a valid load restarts the second, a pause freezes the phase.
  always_comb begin
    cnt_d = cnt_q;
    if (load_ok) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  mod_counter #(.MAX(SEC_MAX), .W(FIELD_W)) u_sec (
    .clk      (clk),
    .rset     (rset),
    .inc      (tick_eff),
    .load     (load_ok),
    .load_val (set_sec),
    .value    (sec_int),
    .carry    (sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX), .W(FIELD_W)) u_min (
    .clk      (clk),
    .rset     (rset),
    .inc      (sec_carry),
    .load     (load_ok),
    .load_val (set_min),
    .value    (min_int),
    .carry    (min_carry)
  );

  mod_counter #(.MAX(HOUR_MAX), .W(FIELD_W)) u_hour (
    .clk      (clk),
    .rset     (rset),
    .inc      (min_carry),
    .load     (load_ok),
    .load_val (set_hour),
    .value    (hour_int),
    .carry    (hour_carry)
  );

  // Pulse sources: a discarded tick produces no sec_tick or day_tick.
  always_comb begin
    sec_tick_d = tick_eff;
    day_tick_d = hour_carry;
    set_err_d  = set_vld && !load_in_range;
`ifdef RTC_ALARM_EN
    set_err_d  = set_err_d || (alarm_set && !alarm_in_range);
`endif
  end

  // One-cycle status pulses aligned with the updated time.
  always_ff @(posedge clk) begin
    if (rset) begin
      set_err_q  <= 1'b0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      set_err_q  <= set_err_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
    end
  end

  // Display hour: 24-hour passthrough or 12-hour mapping; stored time untouched.
  always_comb begin
    hour = hour_int;
    pm   = (hour_int >= NOON_V);
    if (mode12) begin
      if (hour_int == '0) begin
        hour = NOON_V;
      end else if (hour_int > NOON_V) begin
        hour = hour_int - NOON_V;
      end
    end
  end

  assign sec      = sec_int;
  assign min      = min_int;
  assign set_err  = set_err_q;
  assign sec_tick = sec_tick_q;
  assign day_tick = day_tick_q;

`ifdef RTC_ALARM_EN
  // Time the clock lands on after a tick or a load, compared against the alarm.
  always_comb begin
    land_tick.sec  = (sec_int == SEC_LIM) ? '0 : 6'(sec_int) + 6'd1;
    land_tick.min  = 6'(min_int);
    land_tick.hour = 5'(hour_int);
    if (sec_int == SEC_LIM) begin
      land_tick.min = (min_int == MIN_LIM) ? '0 : 6'(min_int) + 6'd1;
      if (min_int == MIN_LIM) begin
        land_tick.hour = (hour_int == HOUR_LIM) ? '0 : 5'(hour_int) + 5'd1;
      end
    end
    land_load.hour = 5'(set_hour);
    land_load.min  = 6'(set_min);
    land_load.sec  = 6'(set_sec);
    alarm_hit = armed_q && ((tick_eff && (land_tick == alarm_q)) ||
                            (load_ok && (land_load == alarm_q)));
  end

  // Alarm registers: arm on a valid alarm_set, latch the flag until cleared.
  always_comb begin
    alarm_d      = alarm_q;
    armed_d      = armed_q;
    alarm_flag_d = alarm_flag_q;
    if (alarm_ok) begin
      alarm_d.hour = 5'(alarm_hour);
      alarm_d.min  = 6'(alarm_min);
      alarm_d.sec  = '0;
      armed_d      = 1'b1;
    end
    if (alarm_clr) begin
      alarm_flag_d = 1'b0;
    end else if (alarm_hit) begin
      alarm_flag_d = 1'b1;
    end
  end

  // Alarm state register.
  always_ff @(posedge clk) begin
    if (rset) begin
      alarm_q      <= '0;
      armed_q      <= 1'b0;
      alarm_flag_q <= 1'b0;
    end else begin
      alarm_q      <= alarm_d;
      armed_q      <= armed_d;
      alarm_flag_q <= alarm_flag_d;
    end
  end

  assign alarm = alarm_flag_q;
`endif

endmodule

// File: doc/rtc_clock_p.md
Name: rtc_clock_p

Overview:
- Parametrised successor to the basic seconds/minutes/hours counter.
- Generates the 1 s tick from a generic input clock and keeps hh:mm:ss with load/set capability.
- Adds run/pause control, a 12/24-hour display mode and a day-rollover pulse.
- Sits behind the display driver; time-set logic (keys/host) drives the load port.

Parameters:
- CLK_FREQ, 50000000, input clock cycles per second; prescaler terminal count = CLK_FREQ-1; must be >= 2.
- CNT_W, 32, prescaler width; must satisfy 2^CNT_W > CLK_FREQ.
- FIELD_W, 8, width of sec/min/hour fields (>= 6).

Ports:
- clk, in, 1, system clock.
- rset, in, 1, reset: synchronous, active-high.
- run, in, 1, 1 = time advances; 0 = prescaler and time frozen.
- mode12, in, 1, 1 = 12-hour display; 0 = 24-hour.
- set_vld, in, 1, one-cycle load strobe.
- set_hour, in, FIELD_W, load value, 24-hour form, 0..23.
- set_min, in, FIELD_W, load value, 0..59.
- set_sec, in, FIELD_W, load value, 0..59.
- set_err, out, 1, one-cycle pulse: load rejected (out of range).
- sec, out, FIELD_W, seconds, 0..59.
- min, out, FIELD_W, minutes, 0..59.
- hour, out, FIELD_W, display hour: 0..23 (24 h) or 1..12 (12 h).
- pm, out, 1, 1 when internal hour >= 12 (valid in both modes).
- sec_tick, out, 1, one-cycle pulse on each second advance.
- day_tick, out, 1, one-cycle pulse on 23:59:59 -> 00:00:00.

Behaviour:
- Reset (rset=1 at posedge clk):
  - prescaler=0, internal hour/min/sec=0.
  - set_err=0, sec_tick=0, day_tick=0, pm=0.
  - hour output = 0 (24 h) or 12 (12 h).
  - Reset mid-count discards any partial second.
- Prescaler:
  - When run=1, counts 0..CLK_FREQ-1 and wraps to 0.
  - tick is asserted combinationally when run=1 and prescaler==CLK_FREQ-1.
  - When run=0, prescaler holds its value; no ticks occur.
- Time chain:
  - On tick: sec increments; at 59 it wraps to 0 and carries to min.
  - min at 59 wraps to 0 and carries to hour.
  - hour at 23 wraps to 0 and raises day carry.
  - All fields update in the same clock edge (ripple carry is combinational, no per-stage latency).
- Registered pulses:
  - sec_tick is asserted the cycle after tick, coincident with the updated sec value.
  - day_tick is asserted in the same cycle as 00:00:00 appearing.
- Load:
  - set_vld with all fields in range loads hour/min/sec and clears the prescaler to 0.
  - If load and tick coincide, load wins and the tick is discarded.
  - Any field out of range: no register changes; set_err pulses the next cycle.
  - Load works regardless of run.
- 12-hour mapping (combinational from internal hour):
  - 0 -> 12, pm=0.
  - 1..11 -> same, pm=0.
  - 12 -> 12, pm=1.
  - 13..23 -> h-12, pm=1.
  - Toggling mode12 changes only the displayed value, never the stored time.
- Widths:
  - Comparisons use full FIELD_W.
  - Prescaler compare uses CNT_W, with CLK_FREQ-1 cast to CNT_W.

Optional Feature:
- RTC_ALARM_EN defined:
  - Adds inputs alarm_set (1), alarm_hour, alarm_min (FIELD_W), alarm_clr (1), and output alarm (1).
  - alarm_set latches the alarm time (24-hour form, range-checked as for load; an invalid value pulses set_err).
  - alarm rises when internal time reaches alarm_hour:alarm_min:00 on a tick, or via a load that lands exactly there.
  - alarm holds until alarm_clr or rset.
  - Alarm registers reset to 0:00 disarmed; only alarm_set arms them.
- Undefined: no alarm ports or logic.

Decomposition:
- Package rtc_pkg holds:
  - SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, HOUR12_NOON=12.
  - a typedef for the time triple {hour,min,sec}.
- One natural sub-module, mod_counter:
  - parameter MAX; ports clk, rset, inc, load, load_val.
  - outputs value and carry (inc && value==MAX).
  - Instantiated three times for sec/min/hour.

Test Plan:
- CLK_FREQ=4, reset, run=1 -> sec_tick every 4 cycles; sec reads 1 after the 4th cycle; min=0, hour=0.
- Load 23:59:58, run 8 cycles -> sec 59 then 00:00:00 with day_tick=1 for exactly one cycle; sec_tick coincident.
- run=0 for 10 cycles mid-second, then run=1 -> time unchanged during the pause; next tick after the remaining prescaler cycles (no lost or extra count).
- set_min=60 with set_vld -> time unchanged, set_err=1 for one cycle; set_hour=13 with mode12=1 -> hour=1, pm=1; internal 0 -> hour=12, pm=0.
- set_vld coincident with tick, loading 05:06:07 -> reads exactly 05:06:07; next tick after 4 full cycles gives 05:06:08.
- RTC_ALARM_EN: alarm 00:01, load 00:00:59 -> alarm=1 on the next tick and held; alarm_clr -> 0; rset mid-count -> all outputs 0, hour=12 if mode12.
